// File: rtl/cpu_pkg.sv
// Shared CPU types: CACHE instruction codes, tag-array entry layout and cache geometry.
package cpu_pkg;

  localparam int unsigned CACHE_WAYS = 4;
  localparam int unsigned CACHE_SETS = 256;
  localparam int unsigned TAG_W      = 20;
  localparam int unsigned SET_W      = 8;
  localparam int unsigned WAY_W      = 2;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned ADDR_W     = 32;

  // {op[4:2], cache[1:0]}; cache 2'b00 = I-cache, 2'b01 = D-cache
  typedef enum logic [4:0] {
    I_INDEX_INVALID    = 5'b000_00,
    D_INDEX_WB_INVALID = 5'b000_01,
    I_INDEX_STORE_TAG  = 5'b010_00,
    D_INDEX_STORE_TAG  = 5'b010_01,
    I_HIT_INVALID      = 5'b100_00,
    D_HIT_INVALID      = 5'b100_01,
    D_HIT_WB_INVALID   = 5'b101_01
  } CacheCodeType;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             v;
    logic             d;
  } cache_tag_t;

  function automatic logic op_is_store_tag(input CacheCodeType op);
    logic [4:0] c;
    c = 5'(op);
    return c[4:2] == 3'b010;
  endfunction

  function automatic logic op_is_hit(input CacheCodeType op);
    logic [4:0] c;
    c = 5'(op);
    return c[4];
  endfunction

  function automatic logic op_is_wb(input CacheCodeType op);
    return (op == D_INDEX_WB_INVALID) || (op == D_HIT_WB_INVALID);
  endfunction

  function automatic logic op_is_icache(input CacheCodeType op);
    logic [4:0] c;
    c = 5'(op);
    return c[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/cache_op_unit_match.sv
// 4-way tag compare: lowest valid way whose tag equals the lookup tag.
module cache_tag_match
  import cpu_pkg::*;
(
  input  cache_tag_t       tags_i [CACHE_WAYS],
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_c_o,
  output logic [WAY_W-1:0] hit_way_c_o
);

  logic unused_dirty;

  always_comb begin
    hit_c_o      = 1'b0;
    hit_way_c_o  = '0;
    unused_dirty = 1'b0;
    for (int unsigned w = 0; w < CACHE_WAYS; w++) begin
      unused_dirty = unused_dirty ^ tags_i[w].d;
      if (!hit_c_o && tags_i[w].v && (tags_i[w].tag == lookup_tag_i)) begin
        hit_c_o     = 1'b1;
        hit_way_c_o = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_op_unit.sv
// CACHE instruction sequencer: tag read/compare, optional dirty-line writeback, tag update.
// Writeback path is built only when CACHE_OP_WB_EN is defined; otherwise writeback ops just invalidate.
module cache_op_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              done,
  input  CacheCodeType      cache_op,
  input  logic [SET_W-1:0]  cache_index,
  input  logic [WAY_W-1:0]  cache_way,
  input  logic [TAG_W-1:0]  cache_tag,
  input  logic              cache_valid,
  input  logic              cache_dirty,
  output logic              tag_en,
  output logic              tag_we,
  output logic              tag_icache,
  output logic [SET_W-1:0]  tag_set,
  output logic [WAY_W-1:0]  tag_wway,
  output cache_tag_t        tag_wdata,
  input  cache_tag_t        tag_rdata [CACHE_WAYS],
  output logic              data_en,
  output logic [WAY_W-1:0]  data_way,
  input  logic [LINE_W-1:0] data_rline,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [LINE_W-1:0] wb_data
);

`ifdef CACHE_OP_WB_EN
  typedef enum logic [2:0] {IDLE, TAG_RD, TAG_CMP, WB_RD, WB_REQ, TAG_WR, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, TAG_RD, TAG_CMP, TAG_WR, DONE} state_e;
`endif

  state_e           state_q, state_d;
  CacheCodeType     op_q, op_d;
  logic [SET_W-1:0] index_q, index_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             icache_q, icache_d;
  logic             req_ready_q, req_ready_d;
  logic             done_q, done_d;
  logic             tag_en_q, tag_en_d;
  logic             tag_we_q, tag_we_d;
  logic [WAY_W-1:0] tag_wway_q, tag_wway_d;
  cache_tag_t       tag_wdata_q, tag_wdata_d;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] tgt_way;
  cache_tag_t       tgt;

`ifdef CACHE_OP_WB_EN
  logic              data_en_q, data_en_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [LINE_W-1:0] line_q, line_d;
`endif

  cache_tag_match u_match (
    .tags_i       (tag_rdata),
    .lookup_tag_i (tag_q),
    .hit_c_o      (hit),
    .hit_way_c_o  (hit_way)
  );

  // Hit ops act on the matching way, Index ops on the latched way
  assign tgt_way = op_is_hit(op_q) ? hit_way : way_q;
  assign tgt     = tag_rdata[tgt_way];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    index_d     = index_q;
    way_d       = way_q;
    tag_d       = tag_q;
    icache_d    = icache_q;
    tag_wway_d  = tag_wway_q;
    tag_wdata_d = tag_wdata_q;
`ifdef CACHE_OP_WB_EN
    wb_addr_d   = wb_addr_q;
    line_d      = line_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d     = cache_op;
          index_d  = cache_index;
          way_d    = cache_way;
          tag_d    = cache_tag;
          icache_d = op_is_icache(cache_op);
          if (op_is_store_tag(cache_op)) begin
            state_d     = TAG_WR;
            tag_wway_d  = cache_way;
            tag_wdata_d = '{tag: cache_tag, v: cache_valid, d: cache_dirty};
          end else begin
            state_d = TAG_RD;
          end
        end
      end
      TAG_RD:  state_d = TAG_CMP;
      TAG_CMP: begin
        tag_wway_d  = tgt_way;
        tag_wdata_d = '{tag: tgt.tag, v: 1'b0, d: 1'b0};
        if (op_is_hit(op_q) && !hit) begin
          state_d = DONE;
        end
`ifdef CACHE_OP_WB_EN
        else if (op_is_wb(op_q) && tgt.v && tgt.d) begin
          state_d   = WB_RD;
          wb_addr_d = {tgt.tag, index_q, 4'b0000};
        end
`endif
        else begin
          state_d = TAG_WR;
        end
      end
`ifdef CACHE_OP_WB_EN
      WB_RD: begin
        line_d  = data_rline;
        state_d = WB_REQ;
      end
      WB_REQ: begin
        if (wb_ready) state_d = TAG_WR;
      end
`endif
      TAG_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered as a decode of the next state
    req_ready_d = (state_d == IDLE);
    done_d      = (state_d == DONE);
    tag_en_d    = (state_d == TAG_RD);
    tag_we_d    = (state_d == TAG_WR);
`ifdef CACHE_OP_WB_EN
    data_en_d   = (state_d == WB_RD);
    wb_valid_d  = (state_d == WB_REQ);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= I_INDEX_INVALID;
      index_q     <= '0;
      way_q       <= '0;
      tag_q       <= '0;
      icache_q    <= 1'b0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      tag_en_q    <= 1'b0;
      tag_we_q    <= 1'b0;
      tag_wway_q  <= '0;
      tag_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      index_q     <= index_d;
      way_q       <= way_d;
      tag_q       <= tag_d;
      icache_q    <= icache_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      tag_en_q    <= tag_en_d;
      tag_we_q    <= tag_we_d;
      tag_wway_q  <= tag_wway_d;
      tag_wdata_q <= tag_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign done       = done_q;
  assign tag_en     = tag_en_q;
  assign tag_we     = tag_we_q;
  assign tag_icache = icache_q;
  assign tag_set    = index_q;
  assign tag_wway   = tag_wway_q;
  assign tag_wdata  = tag_wdata_q;

`ifdef CACHE_OP_WB_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_en_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      line_q     <= '0;
    end else begin
      data_en_q  <= data_en_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      line_q     <= line_d;
    end
  end

  assign data_en  = data_en_q;
  assign data_way = tag_wway_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = line_q;
`else
  logic unused_c;
  assign unused_c = ^{data_rline, wb_ready, tgt.v, tgt.d};

  assign data_en  = 1'b0;
  assign data_way = '0;
  assign wb_valid = 1'b0;
  assign wb_addr  = '0;
  assign wb_data  = '0;
`endif

endmodule
